// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-level helpers (S-box, xtime, MixColumns)
// for the iterative encryption engine.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // 2a^3b^c^d rewritten as xtime(a^b)^b^c^d for each output row.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0 ^ a1) ^ a1 ^ a2 ^ a3,
                xtime(a1 ^ a2) ^ a2 ^ a3 ^ a0,
                xtime(a2 ^ a3) ^ a3 ^ a0 ^ a1,
                xtime(a3 ^ a0) ^ a0 ^ a1 ^ a2};
    endfunction

endpackage

// File: rtl/aes128_iter_engine_if.sv
// Valid/ready input (plaintext + key) and output (ciphertext) channels of the AES engine.
interface aes128_iter_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_round_step.sv
// One combinational AES-128 round: derives the next round key on the fly, then
// SubBytes/ShiftRows/MixColumns (skipped on the last round)/AddRoundKey.
module aes_round_step
    import aes_pkg::*;
(
    input  aes_block_t  state_in,
    input  aes_block_t  key_in,
    input  logic [7:0]  rcon_in,
    input  logic        last,
    output aes_block_t  state_out,
    output aes_block_t  key_out,
    output logic [7:0]  rcon_out
);

    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    aes_block_t  sb, sr, mc;

    always_comb begin
        w0 = key_in[127:96];
        w1 = key_in[95:64];
        w2 = key_in[63:32];
        w3 = key_in[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_in, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        key_out = {n0, n1, n2, n3};

        sb = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            sb[127 - 8 * k -: 8] = sbox(state_in[127 - 8 * k -: 8]);
        end

        // Byte index is 4*column + row; row r rotates left by r columns.
        sr = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sr[127 - 8 * (4 * c + r) -: 8] = sb[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
            end
        end

        mc = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            mc[127 - 32 * c -: 32] = mix_column(sr[127 - 32 * c -: 32]);
        end

        state_out = (last ? sr : mc) ^ key_out;
        rcon_out  = xtime(rcon_in);
    end

endmodule

// File: rtl/aes128_iter_engine.sv
// Iterative AES-128 encryptor, ROUNDS_PER_CYCLE rounds per clock with on-the-fly key schedule.
// Optional build macro AES_ZEROIZE_EN clears state, key and ciphertext on the output handshake.
module aes128_iter_engine
    import aes_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    aes128_iter_engine_if.slave  bus,
    output logic                 busy,
    output logic [3:0]           round_idx
);

    localparam int         LAT  = AES_NR / ROUNDS_PER_CYCLE;
    localparam logic [3:0] STEP = 4'(ROUNDS_PER_CYCLE);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rounds
        $error("aes128_iter_engine: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10 (LAT=%0d)", LAT);
    end

    aes_state_e  st_q;
    aes_block_t  state_reg;
    aes_block_t  key_reg;
    logic [7:0]  rcon_reg;
    aes_block_t  out_data_q;
    logic        out_valid_q;
    logic        in_ready_q;
    logic        busy_q;
    logic [3:0]  round_idx_q;

    aes_block_t  chain_state [ROUNDS_PER_CYCLE + 1];
    aes_block_t  chain_key   [ROUNDS_PER_CYCLE + 1];
    logic [7:0]  chain_rcon  [ROUNDS_PER_CYCLE + 1];
    logic [ROUNDS_PER_CYCLE-1:0] last_round;
    logic        final_step;

    assign chain_state[0] = state_reg;
    assign chain_key[0]   = key_reg;
    assign chain_rcon[0]  = rcon_reg;

    for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_round
        localparam logic [3:0] RND = 4'(i + 1);
        assign last_round[i] = (round_idx_q + RND == 4'(AES_NR));

        aes_round_step u_step (
            .state_in  (chain_state[i]),
            .key_in    (chain_key[i]),
            .rcon_in   (chain_rcon[i]),
            .last      (last_round[i]),
            .state_out (chain_state[i+1]),
            .key_out   (chain_key[i+1]),
            .rcon_out  (chain_rcon[i+1])
        );
    end

    assign final_step = (round_idx_q + STEP == 4'(AES_NR));

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q        <= IDLE;
            state_reg   <= '0;
            key_reg     <= '0;
            rcon_reg    <= 8'h01;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            round_idx_q <= '0;
        end else begin
            case (st_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_reg   <= bus.in_data ^ bus.in_key;
                        key_reg     <= bus.in_key;
                        rcon_reg    <= 8'h01;
                        round_idx_q <= '0;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        st_q        <= RUN;
                    end
                end
                RUN: begin
                    state_reg   <= chain_state[ROUNDS_PER_CYCLE];
                    key_reg     <= chain_key[ROUNDS_PER_CYCLE];
                    rcon_reg    <= chain_rcon[ROUNDS_PER_CYCLE];
                    round_idx_q <= round_idx_q + STEP;
                    if (final_step) begin
                        out_data_q  <= chain_state[ROUNDS_PER_CYCLE];
                        out_valid_q <= 1'b1;
                        st_q        <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        st_q        <= IDLE;
`ifdef AES_ZEROIZE_EN
                        state_reg   <= '0;
                        key_reg     <= '0;
                        out_data_q  <= '0;
`endif
                    end
                end
                default: begin
                    st_q        <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_q;
    assign round_idx     = round_idx_q;

endmodule

// File: tb/tb_aes128_iter_engine.sv
// Self-checking bench for aes128_iter_engine: known-answer and random vectors against a
// byte-array AES-128 model, plus backpressure, back-to-back, mid-run reset and unroll sweeps.
module tb_aes128_iter_engine;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    aes128_iter_engine_if bus1 ();
    aes128_iter_engine_if bus2 ();
    aes128_iter_engine_if bus5 ();
    aes128_iter_engine_if bus10 ();
    logic       busy1, busy2, busy5, busy10;
    logic [3:0] ridx1, ridx2, ridx5, ridx10;

    aes128_iter_engine #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .busy(busy1), .round_idx(ridx1));
    aes128_iter_engine #(.ROUNDS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .busy(busy2), .round_idx(ridx2));
    aes128_iter_engine #(.ROUNDS_PER_CYCLE(5)) u_dut5 (
        .clk(clk), .reset(reset), .bus(bus5), .busy(busy5), .round_idx(ridx5));
    aes128_iter_engine #(.ROUNDS_PER_CYCLE(10)) u_dut10 (
        .clk(clk), .reset(reset), .bus(bus10), .busy(busy10), .round_idx(ridx10));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb_tab [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse (x^254) followed by the FIPS-197 affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = (x == 8'h00) ? 8'h00 : 8'h01;
        if (x != 8'h00)
            for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a [4];
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127 - 8 * k -: 8] ^ w[k / 4][31 - 8 * (k % 4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) s[k] = sb_tab[s[k]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) t[4 * c + row] = s[4 * ((c + row) % 4) + row];
            for (int c = 0; c < 4; c++) begin
                for (int row = 0; row < 4; row++) a[row] = t[4 * c + row];
                for (int row = 0; row < 4; row++) begin
                    if (r < 10)
                        s[4 * c + row] = gmul(8'h02, a[row]) ^ gmul(8'h03, a[(row + 1) % 4]) ^
                                         a[(row + 2) % 4] ^ a[(row + 3) % 4];
                    else
                        s[4 * c + row] = a[row];
                    s[4 * c + row] = s[4 * c + row] ^ w[4 * r + c][31 - 8 * row -: 8];
                end
            end
        end
        for (int k = 0; k < 16; k++) res[127 - 8 * k -: 8] = s[k];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- stimulus helpers ----------------
    // Offers one block to the RPC=1 engine, tracks round_idx, holds out_ready low for
    // `hold` cycles while wiggling the input side, then completes the handshake.
    task automatic run_block(input logic [127:0] key, input logic [127:0] pt, input int hold,
                             output logic [127:0] ct, output int lat);
        @(negedge clk);
        chk("accept_ready", bus1.in_ready, 1'b1);
        bus1.in_valid  = 1'b1;
        bus1.in_data   = pt;
        bus1.in_key    = key;
        bus1.out_ready = (hold == 0);
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        bus1.in_data  = rnd128();
        bus1.in_key   = rnd128();
        lat = -1;
        ct  = '0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (c <= 10) chk($sformatf("round_idx_c%0d", c), ridx1, 128'(c));
            if (bus1.out_valid) begin
                lat = c;
                ct  = bus1.out_data;
                break;
            end
        end
        chk("latency", 128'(lat), 128'd10);
        if (lat > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                bus1.in_valid = 1'($urandom_range(0, 1));
                bus1.in_data  = rnd128();
                @(posedge clk); #1;
                chk("bp_state", {bus1.out_valid, bus1.in_ready, busy1}, 3'b101);
                chk("bp_data", bus1.out_data, ct);
            end
            if (hold > 0) begin
                @(negedge clk);
                bus1.in_valid  = 1'b0;
                bus1.out_ready = 1'b1;
            end
            @(posedge clk); #1;
            chk("handshake_idle", {bus1.out_valid, bus1.in_ready, busy1}, 3'b010);
        end
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           hold;
    } vec_t;

    vec_t vecs [10];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        logic [127:0] ct, ct2, ct5, ct10;
        int lat, lat2, lat5, lat10, cyc;
        int acc [$];
        logic [127:0] res [$];
        logic seen;

        reset = 1'b0;
        bus1.in_valid = 1'b0;  bus1.in_data = '0;  bus1.in_key = '0;  bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0;  bus2.in_data = '0;  bus2.in_key = '0;  bus2.out_ready = 1'b1;
        bus5.in_valid = 1'b0;  bus5.in_data = '0;  bus5.in_key = '0;  bus5.out_ready = 1'b1;
        bus10.in_valid = 1'b0; bus10.in_data = '0; bus10.in_key = '0; bus10.out_ready = 1'b1;

        for (int i = 0; i < 256; i++) sb_tab[i] = sbox_calc(8'(i));

        vecs[0] = '{C1_KEY, C1_PT, C1_CT, 0};
        vecs[1] = '{B_KEY, B_PT, B_CT, 20};
        for (int i = 2; i < 10; i++) begin
            vecs[i].key  = rnd128();
            vecs[i].pt   = rnd128();
            vecs[i].ct   = aes_ref(vecs[i].pt, vecs[i].key);
            vecs[i].hold = int'($urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", {bus1.in_ready, bus1.out_valid, busy1}, 3'b100);
        chk("reset_round_idx", ridx1, 0);
        chk("reset_out_data", bus1.out_data, 0);
        @(negedge clk);
        reset = 1'b1;

        // Known-answer and random vectors on the single-round engine.
        for (int i = 0; i < 10; i++) begin
            run_block(vecs[i].key, vecs[i].pt, vecs[i].hold, ct, lat);
            chk($sformatf("vec%0d_ct", i), ct, vecs[i].ct);
        end

        // Unroll sweep: the same App. B block into the 2-, 5- and 10-round engines.
        @(negedge clk);
        bus2.in_valid = 1'b1;  bus2.in_data = B_PT;  bus2.in_key = B_KEY;
        bus5.in_valid = 1'b1;  bus5.in_data = B_PT;  bus5.in_key = B_KEY;
        bus10.in_valid = 1'b1; bus10.in_data = B_PT; bus10.in_key = B_KEY;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0; bus5.in_valid = 1'b0; bus10.in_valid = 1'b0;
        lat2 = -1; lat5 = -1; lat10 = -1; ct2 = '0; ct5 = '0; ct10 = '0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (bus2.out_valid && lat2 < 0)  begin lat2 = c;  ct2 = bus2.out_data;
                chk("rpc2_round_idx", ridx2, 10); chk("rpc2_busy", busy2, 1); end
            if (bus5.out_valid && lat5 < 0)  begin lat5 = c;  ct5 = bus5.out_data;
                chk("rpc5_round_idx", ridx5, 10); chk("rpc5_busy", busy5, 1); end
            if (bus10.out_valid && lat10 < 0) begin lat10 = c; ct10 = bus10.out_data;
                chk("rpc10_round_idx", ridx10, 10); chk("rpc10_busy", busy10, 1); end
        end
        chk("rpc2_latency", 128'(lat2), 5);
        chk("rpc5_latency", 128'(lat5), 2);
        chk("rpc10_latency", 128'(lat10), 1);
        chk("rpc2_ct", ct2, B_CT);
        chk("rpc5_ct", ct5, B_CT);
        chk("rpc10_ct", ct10, B_CT);

        // Back-to-back: in_valid held high, C.1 then App. B.
        @(negedge clk);
        bus1.out_ready = 1'b1;
        bus1.in_valid  = 1'b1;
        bus1.in_data   = C1_PT;
        bus1.in_key    = C1_KEY;
        cyc = 0;
        while (res.size() < 2 && cyc < 80) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (acc.size() == 1 && bus1.in_data == C1_PT) begin
                bus1.in_data = B_PT;
                bus1.in_key  = B_KEY;
            end
            if (acc.size() == 2) bus1.in_valid = 1'b0;
            if (bus1.out_valid) res.push_back(bus1.out_data);
            if (bus1.in_valid && bus1.in_ready) acc.push_back(cyc);
        end
        bus1.in_valid = 1'b0;
        chk("b2b_results", 128'(res.size()), 2);
        chk("b2b_accepts", 128'(acc.size()), 2);
        if (res.size() == 2 && acc.size() == 2) begin
            chk("b2b_ct0", res[0], C1_CT);
            chk("b2b_ct1", res[1], B_CT);
            chk("b2b_spacing", 128'(acc[1] - acc[0]), 12);
        end
        repeat (3) @(posedge clk);

        // Reset in the middle of RUN discards the block.
        @(negedge clk);
        bus1.in_valid = 1'b1;
        bus1.in_data  = C1_PT;
        bus1.in_key   = C1_KEY;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        for (int c = 0; c < 20 && ridx1 != 4'd4; c++) begin
            @(posedge clk); #1;
        end
        chk("rst_reach4", ridx1, 4);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_flags", {bus1.in_ready, bus1.out_valid, busy1}, 3'b100);
        chk("rst_round_idx", ridx1, 0);
        chk("rst_out_data", bus1.out_data, 0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            seen = seen | bus1.out_valid;
        end
        chk("rst_no_out_valid", seen, 0);
        run_block(C1_KEY, C1_PT, 0, ct, lat);
        chk("post_rst_ct", ct, C1_CT);

        // Idle-state ciphertext after the handshake depends on the zeroize build.
        @(posedge clk); #1;
`ifdef AES_ZEROIZE_EN
        chk("zeroize_out_data", bus1.out_data, 0);
`else
        chk("retain_out_data", bus1.out_data, C1_CT);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
